// File: rtl/msx_sd_pkg.sv
// Shared types for the two-requester HPS sector channel arbiter.
package msx_sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } state_e;

    typedef logic req_id_t;

    localparam int NREQ = 2;

endpackage

// File: rtl/rr2_picker.sv
// Two-way round-robin choice: a lone requester wins outright, a tie goes to
// whichever requester did not win last time.
module rr2_picker
    import msx_sd_pkg::*;
(
    input  logic    req0_i,
    input  logic    req1_i,
    input  req_id_t last_i,
    output logic    valid_o,
    output req_id_t winner_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            winner_o = ~last_i;
        end else begin
            winner_o = req1_i;
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares the HPS virtual-disk sector channel between two requesters, holding
// the grant for a whole sector and aborting handshakes that never start.
module sd_req_arbiter
    import msx_sd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 10_000_000,
    parameter int TW          = 24
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic [31:0] r0_lba,
    input  logic        r0_rd,
    input  logic        r0_wr,
    output logic        r0_ack,
    output logic        r0_buff_wr,
    input  logic [7:0]  r0_buff_din,
    output logic        r0_err,

    input  logic [31:0] r1_lba,
    input  logic        r1_rd,
    input  logic        r1_wr,
    output logic        r1_ack,
    output logic        r1_buff_wr,
    input  logic [7:0]  r1_buff_din,
    output logic        r1_err,

    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    state_e          state_q, state_d;
    req_id_t         owner_q, owner_d;
    req_id_t         last_q, last_d;
    logic [31:0]     lba_q, lba_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] blk_q, blk_d;
    logic [NREQ-1:0] err_q, err_d;

    logic [NREQ-1:0] rdVec, wrVec, reqVec;
    logic [NREQ-1:0] ackVec, buffWrVec;
    logic            pickValid;
    req_id_t         pickWinner;

    // A requester that timed out stays masked until it lowers both rd and wr.
    always_comb begin
        rdVec  = {r1_rd, r0_rd};
        wrVec  = {r1_wr, r0_wr};
        reqVec = (rdVec | wrVec) & ~blk_q;
    end

    rr2_picker u_picker (
        .req0_i   (reqVec[0]),
        .req1_i   (reqVec[1]),
        .last_i   (last_q),
        .valid_o  (pickValid),
        .winner_o (pickWinner)
    );

    // Next-state logic; a read beats a write so the write waits for a later grant.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        err_d   = '0;
        blk_d   = blk_q & (rdVec | wrVec);

        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    state_d = ISSUE;
                    owner_d = pickWinner;
                    last_d  = pickWinner;
                    lba_d   = pickWinner ? r1_lba : r0_lba;
                    rd_d    = rdVec[pickWinner];
                    wr_d    = wrVec[pickWinner] & ~rdVec[pickWinner];
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (sd_ack) begin
                    state_d = XFER;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d        = IDLE;
                    rd_d           = 1'b0;
                    wr_d           = 1'b0;
                    cnt_d          = '0;
                    err_d[owner_q] = 1'b1;
                    blk_d[owner_q] = 1'b1;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            blk_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
        end
    end

    // Data-phase routing is combinational so HPS sees write data in the same cycle.
    always_comb begin
        ackVec      = '0;
        buffWrVec   = '0;
        sd_buff_din = '0;
        if (state_q == XFER) begin
            ackVec[owner_q]    = sd_ack;
            buffWrVec[owner_q] = sd_buff_wr;
            sd_buff_din        = owner_q ? r1_buff_din : r0_buff_din;
        end
    end

    assign r0_ack     = ackVec[0];
    assign r1_ack     = ackVec[1];
    assign r0_buff_wr = buffWrVec[0];
    assign r1_buff_wr = buffWrVec[1];
    assign r0_err     = err_q[0];
    assign r1_err     = err_q[1];
    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Randomised and directed checks of sd_req_arbiter against a request-level
// model of round-robin arbitration, blocking and data routing.
module tb_sd_req_arbiter;

    localparam int TO = 16;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] r0_lba, r1_lba;
    logic        r0_rd, r0_wr, r1_rd, r1_wr;
    logic        r0_ack, r1_ack, r0_buff_wr, r1_buff_wr, r0_err, r1_err;
    logic [7:0]  r0_buff_din, r1_buff_din;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;

    int errCount   = 0;
    int checkCount = 0;
    int mLast;
    bit mBlk[2];

    always #5 clk_sys = ~clk_sys;

    sd_req_arbiter #(.TIMEOUT_CYC(TO), .TW(5)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .r0_lba      (r0_lba),
        .r0_rd       (r0_rd),
        .r0_wr       (r0_wr),
        .r0_ack      (r0_ack),
        .r0_buff_wr  (r0_buff_wr),
        .r0_buff_din (r0_buff_din),
        .r0_err      (r0_err),
        .r1_lba      (r1_lba),
        .r1_rd       (r1_rd),
        .r1_wr       (r1_wr),
        .r1_ack      (r1_ack),
        .r1_buff_wr  (r1_buff_wr),
        .r1_buff_din (r1_buff_din),
        .r1_err      (r1_err),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic ackOf(input int n);
        return (n == 1) ? r1_ack : r0_ack;
    endfunction

    function automatic logic errOf(input int n);
        return (n == 1) ? r1_err : r0_err;
    endfunction

    function automatic logic buffWrOf(input int n);
        return (n == 1) ? r1_buff_wr : r0_buff_wr;
    endfunction

    // Reference arbitration: a lone unblocked requester wins, a tie goes to the one not served last.
    function automatic int predictOwner();
        bit want0;
        bit want1;
        want0 = (r0_rd || r0_wr) && !mBlk[0];
        want1 = (r1_rd || r1_wr) && !mBlk[1];
        if (want0 && want1) return 1 - mLast;
        if (want0) return 0;
        if (want1) return 1;
        return -1;
    endfunction

    task automatic clearInputs();
        r0_rd = 0; r0_wr = 0; r1_rd = 0; r1_wr = 0;
        sd_ack = 0; sd_buff_wr = 0;
    endtask

    task automatic modelReset();
        mLast   = 1;
        mBlk[0] = 0;
        mBlk[1] = 0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        modelReset();
    endtask

    task automatic dropOp(input int n, input bit wasRd);
        if (n == 0) begin
            if (wasRd) r0_rd = 0; else r0_wr = 0;
        end else begin
            if (wasRd) r1_rd = 0; else r1_wr = 0;
        end
    endtask

    // Plays the HPS side of one transaction: waits for a grant, then acks and
    // streams bytes, or withholds ack to force a timeout.
    task automatic applyStimulus(input int ackDelay, input int nbytes, input bit doTimeout,
                                 input bit dropOnErr, input int resetAt, output int won);
        int          exp;
        bit          seen;
        bit          expRd;
        logic [31:0] expLba;
        int          ownCnt;
        int          othCnt;
        won    = -1;
        ownCnt = 0;
        othCnt = 0;
        exp    = predictOwner();
        seen   = 0;
        for (int k = 0; k < 10; k++) begin
            if (sd_rd || sd_wr) begin
                seen = 1;
                break;
            end
            tick();
        end
        checkOutput("grant_seen", 32'(seen), (exp >= 0) ? 32'd1 : 32'd0);
        if (!seen || exp < 0) return;

        expRd  = (exp == 1) ? r1_rd : r0_rd;
        expLba = (exp == 1) ? r1_lba : r0_lba;
        checkOutput("sd_lba", sd_lba, expLba);
        checkOutput("sd_rd", 32'(sd_rd), 32'(expRd));
        checkOutput("sd_wr", 32'(sd_wr), 32'(!expRd));
        mLast = exp;

        if (doTimeout) begin
            for (int k = 1; k < TO; k++) begin
                tick();
                checkOutput("issue_hold", 32'(sd_rd | sd_wr), 32'd1);
            end
            tick();
            checkOutput("timeout_drop", 32'(sd_rd | sd_wr), 32'd0);
            checkOutput("timeout_err_own", 32'(errOf(exp)), 32'd1);
            checkOutput("timeout_err_other", 32'(errOf(1 - exp)), 32'd0);
            won = errOf(1) ? 1 : 0;
            mBlk[exp] = 1;
            if (dropOnErr) begin
                if (exp == 0) begin r0_rd = 0; r0_wr = 0; end
                else begin r1_rd = 0; r1_wr = 0; end
                mBlk[exp] = 0;
            end
            tick();
            checkOutput("err_one_cycle", 32'(errOf(exp)), 32'd0);
            return;
        end

        repeat (ackDelay) begin
            tick();
            checkOutput("issue_hold", 32'(sd_rd | sd_wr), 32'd1);
        end
        sd_ack = 1;
        #1;
        checkOutput("ack_gated_in_issue", 32'(ackOf(exp)), 32'd0);
        tick();
        checkOutput("ack_clears_req", 32'(sd_rd | sd_wr), 32'd0);
        checkOutput("ack_owner", 32'(ackOf(exp)), 32'd1);
        checkOutput("ack_other", 32'(ackOf(1 - exp)), 32'd0);
        won = r1_ack ? 1 : 0;
        dropOp(exp, expRd);

        for (int b = 0; b < nbytes; b++) begin
            if (b == resetAt) begin
                reset = 1;
                tick();
                checkOutput("rst_req", 32'(sd_rd | sd_wr), 32'd0);
                checkOutput("rst_lba", sd_lba, 32'd0);
                checkOutput("rst_ack", 32'({r1_ack, r0_ack}), 32'd0);
                checkOutput("rst_buff_wr", 32'({r1_buff_wr, r0_buff_wr}), 32'd0);
                checkOutput("rst_buff_din", 32'(sd_buff_din), 32'd0);
                checkOutput("rst_err", 32'({r1_err, r0_err}), 32'd0);
                reset = 0;
                clearInputs();
                modelReset();
                return;
            end
            sd_buff_wr = expRd;
            #1;
            if (buffWrOf(exp)) ownCnt++;
            if (buffWrOf(1 - exp)) othCnt++;
            checkOutput("buff_din", 32'(sd_buff_din), (exp == 1) ? 32'(r1_buff_din) : 32'(r0_buff_din));
            tick();
        end
        sd_buff_wr = 0;
        checkOutput("buff_wr_owner_count", ownCnt, expRd ? nbytes : 0);
        checkOutput("buff_wr_other_count", othCnt, 0);
        sd_ack = 0;
        #1;
        checkOutput("ack_fall", 32'(ackOf(exp)), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         won;
        logic [1:0] op;

        reset = 1;
        clearInputs();
        r0_lba = 32'h0; r1_lba = 32'h0;
        r0_buff_din = 8'h3C; r1_buff_din = 8'hA5;
        r0_rd = 1; sd_ack = 1; sd_buff_wr = 1;
        repeat (3) tick();
        checkOutput("reset_sd_rd", 32'(sd_rd), 32'd0);
        checkOutput("reset_sd_wr", 32'(sd_wr), 32'd0);
        checkOutput("reset_sd_lba", sd_lba, 32'd0);
        checkOutput("reset_ack", 32'({r1_ack, r0_ack}), 32'd0);
        checkOutput("reset_buff_wr", 32'({r1_buff_wr, r0_buff_wr}), 32'd0);
        checkOutput("reset_buff_din", 32'(sd_buff_din), 32'd0);
        checkOutput("reset_err", 32'({r1_err, r0_err}), 32'd0);
        r0_rd = 0;
        reset = 0;
        modelReset();
        tick();
        checkOutput("spurious_ack_idle", 32'({r1_ack, r0_ack}), 32'd0);
        checkOutput("spurious_buff_wr_idle", 32'({r1_buff_wr, r0_buff_wr}), 32'd0);
        checkOutput("spurious_din_idle", 32'(sd_buff_din), 32'd0);
        clearInputs();
        tick();

        $display("[TB] single read, 512 bytes");
        r0_lba = 32'h100; r0_buff_din = 8'h5A; r0_rd = 1;
        applyStimulus(5, 512, 0, 0, -1, won);
        checkOutput("single_owner", won, 0);

        $display("[TB] contention, round robin");
        doReset();
        r0_lba = 32'h200; r1_lba = 32'h300;
        r0_rd = 1; r1_rd = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, 4, 0, 0, -1, won);
            checkOutput("rr_order", won, i % 2);
            if (i < 3) begin
                if (won == 0) r0_rd = 1; else r1_rd = 1;
            end
        end
        r0_rd = 0; r1_rd = 0;
        repeat (3) tick();

        $display("[TB] write data routing");
        r1_lba = 32'h400; r1_buff_din = 8'hA5; r0_buff_din = 8'h3C; r1_wr = 1;
        applyStimulus(1, 8, 0, 0, -1, won);
        checkOutput("write_owner", won, 1);
        repeat (2) tick();

        $display("[TB] read and write together");
        r0_lba = 32'h500; r0_rd = 1; r0_wr = 1;
        applyStimulus(1, 3, 0, 0, -1, won);
        checkOutput("rdwr_wr_still_held", 32'(r0_wr), 32'd1);
        applyStimulus(1, 3, 0, 0, -1, won);
        checkOutput("rdwr_second_owner", won, 0);
        repeat (2) tick();

        $display("[TB] timeout and blocking");
        doReset();
        r0_lba = 32'h600; r0_rd = 1;
        applyStimulus(0, 0, 1, 0, -1, won);
        checkOutput("timeout_owner", won, 0);
        repeat (5) begin
            tick();
            checkOutput("blocked_no_reissue", 32'(sd_rd | sd_wr), 32'd0);
        end
        r1_lba = 32'h700; r1_rd = 1;
        applyStimulus(2, 4, 0, 0, -1, won);
        checkOutput("served_while_blocked", won, 1);
        r0_rd = 0;
        tick();
        mBlk[0] = 0;
        r0_rd = 1;
        applyStimulus(1, 4, 0, 0, -1, won);
        checkOutput("reissue_after_release", won, 0);
        repeat (2) tick();

        $display("[TB] reset mid transfer");
        r0_lba = 32'h800; r0_rd = 1;
        applyStimulus(1, 200, 0, 0, 100, won);
        r1_lba = 32'h900; r1_rd = 1;
        applyStimulus(1, 4, 0, 0, -1, won);
        checkOutput("after_reset_owner", won, 1);
        repeat (2) tick();

        $display("[TB] randomised traffic");
        doReset();
        for (int it = 0; it < 60; it++) begin
            if (!(sd_rd || sd_wr)) begin
                if (!(r0_rd || r0_wr) && $urandom_range(0, 2) != 0) begin
                    op = 2'($urandom_range(1, 3));
                    r0_rd = op[0]; r0_wr = op[1]; r0_lba = $urandom;
                end
                if (!(r1_rd || r1_wr) && $urandom_range(0, 2) != 0) begin
                    op = 2'($urandom_range(1, 3));
                    r1_rd = op[0]; r1_wr = op[1]; r1_lba = $urandom;
                end
            end
            r0_buff_din = 8'($urandom);
            r1_buff_din = 8'($urandom);
            applyStimulus($urandom_range(0, 6), $urandom_range(1, 12),
                          ($urandom_range(0, 4) == 0), 1'b1, -1, won);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
